// File: rtl/rtc_bus_seq_pkg.sv
// Shared types and constants for the RTC bus sequencer: state encoding,
// a_d phase encodings and the channel-to-RTC-register address map.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_SETUP,
    ST_A_STRB,
    ST_A_HOLD,
    ST_D_SETUP,
    ST_D_STRB,
    ST_D_HOLD,
    ST_GAP
  } state_t;

  localparam logic AD_ADDR = 1'b0;
  localparam logic AD_DATA = 1'b1;

  // Selector channel order does not follow RTC register order.
  function automatic logic [7:0] chAddr(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h21;
      4'd1:    return 8'h22;
      4'd2:    return 8'h23;
      4'd3:    return 8'h24;
      4'd4:    return 8'h25;
      4'd5:    return 8'h26;
      4'd6:    return 8'h27;
      4'd7:    return 8'h41;
      4'd8:    return 8'h42;
      4'd9:    return 8'h43;
      4'd10:   return 8'h00;
      4'd11:   return 8'h01;
      4'd12:   return 8'h02;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/rtc_bus_seq_phase_timer.sv
// Phase down-counter shared by all bus phase states: load starts a phase,
// expire marks its last clock, first marks its first clock.
module rtc_phase_timer #(
  parameter int T_PH = 10
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  output logic o_expire,
  output logic o_first
);

  localparam int CW = (T_PH > 1) ? $clog2(T_PH) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(T_PH - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_reset)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= LOAD_VAL;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - CW'(1);
  end

  assign o_expire = (r_cnt == '0);
  assign o_first  = (r_cnt == LOAD_VAL);

endmodule

// File: rtl/rtc_bus_seq.sv
// RTC multiplexed-bus sequencer: write bursts from the byte selector and single reads.
// Optional burst abort enabled by defining RTC_BURST_ABORT_EN.
module rtc_bus_seq #(
  parameter int N_CH = 13,
  parameter int T_PH = 10
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_startWr,
  input  logic       i_startRd,
  input  logic [7:0] i_rdAddr,
  output logic [3:0] o_muxSel,
  output logic       o_muxEn,
  input  logic [7:0] i_muxData,
  output logic [7:0] o_adOut,
  output logic       o_adOe,
  input  logic [7:0] i_adIn,
  output logic       o_aD,
  output logic       o_csN,
  output logic       o_rdN,
  output logic       o_wrN,
  output logic [7:0] o_rdData,
  output logic       o_rdValid,
  output logic       o_busy,
  output logic       o_done
`ifdef RTC_BURST_ABORT_EN
  ,
  input  logic       i_abort,
  output logic       o_aborted
`endif
);

  import rtc_bus_pkg::*;

  state_t     r_state;
  state_t     w_stateNext;
  logic       r_isRead;
  logic       r_muxEn;
  logic [3:0] r_chIdx;
  logic [7:0] r_rdAddr;
  logic [7:0] r_data;
  logic [7:0] r_rdData;
  logic       w_expire;
  logic       w_first;
  logic       w_load;
  logic       w_end;
  logic       w_abortNow;
  logic       w_addrPh;
  logic       w_dataPh;

  rtc_phase_timer #(.T_PH(T_PH)) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (w_load),
    .o_expire (w_expire),
    .o_first  (w_first)
  );

`ifdef RTC_BURST_ABORT_EN
  logic r_abortPend;

  // An abort lets the current bus cycle finish; the pending flag carries it to GAP.
  always_ff @(posedge i_clk) begin
    if (!i_reset)
      r_abortPend <= 1'b0;
    else if (r_state == ST_IDLE)
      r_abortPend <= 1'b0;
    else if (!r_isRead && i_abort)
      r_abortPend <= 1'b1;
  end

  assign w_abortNow = !r_isRead && (r_abortPend || i_abort);
  assign o_aborted  = (r_state == ST_GAP) && w_abortNow;
`else
  assign w_abortNow = 1'b0;
`endif

  assign w_end = r_isRead || (r_chIdx == 4'(N_CH - 1)) || w_abortNow;

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:    if (i_startWr || i_startRd) w_stateNext = ST_A_SETUP;
      ST_A_SETUP: if (w_expire) w_stateNext = ST_A_STRB;
      ST_A_STRB:  if (w_expire) w_stateNext = ST_A_HOLD;
      ST_A_HOLD:  if (w_expire) w_stateNext = ST_D_SETUP;
      ST_D_SETUP: if (w_expire) w_stateNext = ST_D_STRB;
      ST_D_STRB:  if (w_expire) w_stateNext = ST_D_HOLD;
      ST_D_HOLD:  if (w_expire) w_stateNext = ST_GAP;
      ST_GAP:     w_stateNext = w_end ? ST_IDLE : ST_A_SETUP;
      default:    w_stateNext = ST_IDLE;
    endcase
  end

  // Every state change restarts the phase timer.
  assign w_load = (w_stateNext != r_state);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state  <= ST_IDLE;
      r_isRead <= 1'b0;
      r_muxEn  <= 1'b0;
      r_chIdx  <= 4'd0;
      r_rdAddr <= 8'h00;
      r_data   <= 8'h00;
      r_rdData <= 8'h00;
    end else begin
      r_state <= w_stateNext;
      case (r_state)
        ST_IDLE: begin
          if (i_startWr) begin
            r_isRead <= 1'b0;
            r_muxEn  <= 1'b1;
            r_chIdx  <= 4'd0;
          end else if (i_startRd) begin
            r_isRead <= 1'b1;
            r_rdAddr <= i_rdAddr;
          end
        end
        ST_A_HOLD: if (w_expire && !r_isRead) r_data <= i_muxData;
        ST_D_STRB: if (w_expire && r_isRead) r_rdData <= i_adIn;
        ST_GAP: begin
          if (w_end) begin
            r_muxEn <= 1'b0;
            r_chIdx <= 4'd0;
          end else begin
            r_chIdx <= r_chIdx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_addrPh = (r_state == ST_A_SETUP) || (r_state == ST_A_STRB) || (r_state == ST_A_HOLD);
  assign w_dataPh = (r_state == ST_D_SETUP) || (r_state == ST_D_STRB) || (r_state == ST_D_HOLD);

  always_comb begin
    o_csN   = 1'b1;
    o_wrN   = 1'b1;
    o_rdN   = 1'b1;
    o_aD    = AD_ADDR;
    o_adOe  = 1'b0;
    o_adOut = 8'h00;
    if (w_addrPh) begin
      o_csN   = 1'b0;
      o_adOe  = 1'b1;
      o_adOut = r_isRead ? r_rdAddr : chAddr(r_chIdx);
      o_wrN   = (r_state != ST_A_STRB);
    end else if (w_dataPh) begin
      o_csN   = 1'b0;
      o_aD    = AD_DATA;
      o_adOe  = !r_isRead;
      o_adOut = r_isRead ? 8'h00 : r_data;
      o_wrN   = r_isRead || (r_state != ST_D_STRB);
      o_rdN   = !r_isRead || (r_state != ST_D_STRB);
    end
  end

  assign o_muxSel  = r_chIdx;
  assign o_muxEn   = r_muxEn;
  assign o_rdData  = r_rdData;
  assign o_rdValid = r_isRead && (r_state == ST_D_HOLD) && w_first;
  assign o_busy    = (r_state != ST_IDLE);
  assign o_done    = (r_state == ST_GAP) && w_end;

endmodule

// File: tb/tb_rtc_bus_seq.sv
// Self-checking bench for rtc_bus_seq: per-clock bus waveform predicted from
// phase arithmetic (channel, phase = clock offset / T_PH) with random stimulus.
module tb_rtc_bus_seq;

  localparam int N_CH = 13;
  localparam int T_PH = 2;
  localparam int P    = 6 * T_PH + 1;

  logic       clock;
  logic       reset;
  logic       startWr;
  logic       startRd;
  logic [7:0] rdAddr;
  logic [3:0] muxSel;
  logic       muxEn;
  logic [7:0] muxData;
  logic [7:0] adOut;
  logic       adOe;
  logic [7:0] adIn;
  logic       aD;
  logic       csN;
  logic       rdN;
  logic       wrN;
  logic [7:0] rdData;
  logic       rdValid;
  logic       busy;
  logic       done;
  logic       abortIn;
  logic       abortedOut;

  int         nChecks;
  int         nBad;
  logic [7:0] modelRdData;
  logic [7:0] selData [16];
  logic [7:0] addrTable [16];

  rtc_bus_seq #(.N_CH(N_CH), .T_PH(T_PH)) dut (
    .i_clk     (clock),
    .i_reset   (reset),
    .i_startWr (startWr),
    .i_startRd (startRd),
    .i_rdAddr  (rdAddr),
    .o_muxSel  (muxSel),
    .o_muxEn   (muxEn),
    .i_muxData (muxData),
    .o_adOut   (adOut),
    .o_adOe    (adOe),
    .i_adIn    (adIn),
    .o_aD      (aD),
    .o_csN     (csN),
    .o_rdN     (rdN),
    .o_wrN     (wrN),
    .o_rdData  (rdData),
    .o_rdValid (rdValid),
    .o_busy    (busy),
    .o_done    (done)
`ifdef RTC_BURST_ABORT_EN
    ,
    .i_abort   (abortIn),
    .o_aborted (abortedOut)
`endif
  );

`ifndef RTC_BURST_ABORT_EN
  assign abortedOut = 1'b0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] packVec(
    input logic csN_, input logic wrN_, input logic rdN_, input logic aD_,
    input logic oe_, input logic [7:0] ad_, input logic busy_, input logic done_,
    input logic en_, input logic [3:0] sel_, input logic rv_, input logic ab_,
    input logic [7:0] rdd_);
    return {2'b00, csN_, wrN_, rdN_, aD_, oe_, ad_, busy_, done_, en_, sel_, rv_, ab_, rdd_};
  endfunction

  function automatic logic [31:0] actualVec();
    return packVec(csN, wrN, rdN, aD, adOe, adOe ? adOut : 8'h00, busy, done,
                   muxEn, muxSel, rdValid, abortedOut, rdData);
  endfunction

  function automatic logic [31:0] idleVec();
    return packVec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0,
                   1'b0, 4'd0, 1'b0, 1'b0, modelRdData);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Runs one operation and checks every clock of it against the phase model.
  // abortCh >= 0 raises abort on that channel's first clock; stopAt > 0 pulls
  // reset on that clock of the operation instead of letting it finish.
  task automatic applyStimulus(input bit doWr, input bit doRd, input logic [7:0] addr,
                               input bit patternA0, input int abortCh, input int stopAt);
    bit         isRd;
    int         nCh;
    int         len;
    logic [7:0] rdByte;
    isRd   = !doWr;
    rdByte = 8'($urandom);
    for (int i = 0; i < 16; i++)
      selData[i] = patternA0 ? 8'(8'hA0 + i) : 8'($urandom);
    nCh = isRd ? 1 : ((abortCh >= 0 && abortCh < N_CH) ? abortCh + 1 : N_CH);
    len = nCh * P;

    startWr = doWr;
    startRd = doRd;
    rdAddr  = addr;
    @(negedge clock);
    for (int k = 1; k <= len; k++) begin
      int         ch;
      int         r;
      int         ph;
      bit         last;
      logic [7:0] expAd;
      logic [7:0] expRdd;
      ch    = (k - 1) / P;
      r     = (k - 1) % P;
      ph    = (r < 6 * T_PH) ? r / T_PH : 6;
      last  = (ch == nCh - 1);
      expAd = 8'h00;
      if (ph < 3)
        expAd = isRd ? addr : addrTable[ch];
      else if (ph < 6 && !isRd)
        expAd = selData[ch];
      expRdd = (isRd && r >= 5 * T_PH) ? rdByte : modelRdData;
      checkOutput($sformatf("%s ch%0d clk%0d", isRd ? "rd" : "wr", ch, k), actualVec(),
        packVec(ph == 6, !(ph == 1 || (ph == 4 && !isRd)), !(ph == 4 && isRd),
                ph >= 3 && ph < 6, ph < 3 || (ph < 6 && !isRd), expAd, 1'b1,
                ph == 6 && last, !isRd, isRd ? 4'd0 : 4'(ch), isRd && r == 5 * T_PH,
                ph == 6 && last && abortCh >= 0 && !isRd, expRdd));

      if (k == stopAt) begin
        startWr     = 1'b0;
        startRd     = 1'b0;
        reset       = 1'b0;
        modelRdData = 8'h00;
        @(negedge clock);
        checkOutput("mid-cycle reset", actualVec(), idleVec());
        reset = 1'b1;
        return;
      end

      // Selector shows junk during data phases; the bus must keep the latched byte.
      muxData = (ph >= 3 && ph < 6) ? 8'($urandom) : selData[ch];
      adIn    = (r == 5 * T_PH - 1) ? rdByte : 8'($urandom);
      rdAddr  = 8'($urandom);
      startWr = (k < len) && ($urandom_range(0, 15) == 0);
      startRd = (k < len) && ($urandom_range(0, 7) == 0);
      abortIn = (abortCh >= 0 && k == abortCh * P + 1);
      @(negedge clock);
    end
    startWr = 1'b0;
    startRd = 1'b0;
    abortIn = 1'b0;
    if (isRd) modelRdData = rdByte;
    checkOutput("idle after op", actualVec(), idleVec());
  endtask

  initial begin
    nChecks     = 0;
    nBad        = 0;
    modelRdData = 8'h00;
    addrTable   = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h41,
                    8'h42, 8'h43, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00};
    reset   = 1'b0;
    startWr = 1'b0;
    startRd = 1'b0;
    rdAddr  = 8'h00;
    muxData = 8'h00;
    adIn    = 8'h00;
    abortIn = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset state", actualVec(), idleVec());
    reset = 1'b1;
    @(negedge clock);
    checkOutput("idle after reset", actualVec(), idleVec());

    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, -1, 0);
    applyStimulus(1'b0, 1'b1, 8'h23, 1'b0, -1, 0);
    applyStimulus(1'b1, 1'b1, 8'h55, 1'b0, -1, 0);
    for (int n = 0; n < 6; n++) begin
      bit wr;
      wr = ($urandom_range(0, 1) == 1);
      applyStimulus(wr, !wr, 8'($urandom), 1'b0, -1, 0);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clock);
        checkOutput("idle gap", actualVec(), idleVec());
      end
    end

    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, -1, 3 * P + T_PH + 1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, -1, 0);
`ifdef RTC_BURST_ABORT_EN
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 5, 0);
    abortIn = 1'b1;
    @(negedge clock);
    checkOutput("abort in idle", actualVec(), idleVec());
    abortIn = 1'b0;
    applyStimulus(1'b0, 1'b1, 8'h41, 1'b0, -1, 0);
`endif

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule

// File: doc/rtc_bus_seq.md
Name: rtc_bus_seq

Overview:
- Bus sequencer that sits directly downstream of the 13-channel byte selector (sel/r_s/8-bit output).
- Write burst: steps the selector through channels 0..N_CH-1, latches each byte and writes it to the RTC register mapped to that channel over the multiplexed address/data bus (CS/RD/WR/A-D).
- Single read: reads one RTC register and returns the byte to the PicoBlaze port logic.
- Owns all RTC bus strobe timing; nothing else in the design drives the RTC pins.

Parameters:
- N_CH, 13, channels per write burst (1..16)
- T_PH, 10, clocks per bus phase (≥1); 10 = 100 ns at 100 MHz

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start_wr  in  1  one-clock pulse: start write burst
- start_rd  in  1  one-clock pulse: start single read
- rd_addr  in  8  RTC address for single read, sampled with start_rd
- mux_sel  out  4  channel index to selector sel
- mux_en  out  1  drives selector r_s
- mux_data  in  8  selector output byte
- ad_out  out  8  value driven on RTC AD bus
- ad_oe  out  1  1 = FPGA drives AD bus (tristate control at top level)
- ad_in  in  8  AD bus read-back
- a_d  out  1  0 = address phase, 1 = data phase
- cs_n, rd_n, wr_n  out  1 each  RTC strobes, active-low
- rd_data  out  8  last read byte
- rd_valid  out  1  one-clock pulse when rd_data updated
- busy  out  1  high from the clock after an accepted start until operation end
- done  out  1  one-clock pulse at end of burst or read

Behaviour:
- Reset (reset=0 at a clk edge): all outputs 0, except cs_n, rd_n and wr_n = 1. FSM goes to IDLE, channel counter clears.
- Reset mid-cycle: strobes are released at that edge. No partial-cycle completion.
- FSM states: IDLE, A_SETUP, A_STRB, A_HOLD, D_SETUP, D_STRB, D_HOLD, GAP. Each phase state lasts exactly T_PH clocks (phase counter); GAP lasts 1 clock.
- IDLE: start_wr or start_rd accepted; next state A_SETUP. Both high together: write wins, read is dropped. Starts while busy are ignored.
- Write burst:
  - mux_en=1 and mux_sel=0 from acceptance.
  - ad_out = CH_ADDR[idx] during A_*.
  - Data register loads mux_data on the D_SETUP entry edge and drives ad_out through D_*.
  - mux_sel increments in GAP.
- Strobes, cs_n: low in all six phase states, high in IDLE/GAP.
- Strobes, a_d: 0 in A_*, 1 in D_*.
- Strobes, wr_n: low in A_STRB. For writes, also low in D_STRB.
- Strobes, rd_n: low in D_STRB for reads only.
- Strobes, ad_oe: 1 in all phase states, except D_* during a read.
- Read: rd_data captures ad_in on the last clock of D_STRB. rd_valid pulses on the first D_HOLD clock. rd_addr is used as the address.
- GAP after channel N_CH-1 (or after the read): done=1. Next state IDLE; busy and mux_en fall on that IDLE edge.
- Latency: burst = N_CH*(6*T_PH+1) clocks from the first A_SETUP clock; read = 6*T_PH+1.
- Channel index width 4 bits; wrap never occurs because the burst ends at N_CH-1.

Optional Feature:
- Macro: RTC_BURST_ABORT_EN
- Defined: adds input abort (1 bit). abort seen high in any burst state completes the current bus cycle, then goes GAP→IDLE with done=1, skipping the remaining channels. Output aborted (1 bit) pulses with that done. abort has no effect on reads or in IDLE.
- Undefined: no abort/aborted ports; bursts always run all N_CH channels.

Decomposition:
- Package rtc_bus_pkg holds the state enum, a_d encodings, and the CH_ADDR table: channels 0..12 → 0x21,0x22,0x23,0x24,0x25,0x26,0x27,0x41,0x42,0x43,0x00,0x01,0x02.
- One sub-module, rtc_phase_timer: a T_PH down-counter with load/expire signals, shared by every phase state.

Test Plan:
- Reset during A_STRB of channel 3 → next edge cs_n=wr_n=rd_n=1, busy=0, mux_sel=0; a following start_wr restarts at channel 0.
- T_PH=2, N_CH=13, mux_data=0xA0+sel, start_wr →
  - 13 cycles, each with address CH_ADDR[i] then data 0xA0+i.
  - wr_n low 2 clocks per strobe.
  - done on clock 13*13=169; busy low after.
- start_rd with rd_addr=0x23, ad_in=0x59 →
  - ad_oe=0 during D_*, rd_n low 2 clocks, rd_data=0x59.
  - rd_valid one clock, done at clock 13.
- start_wr and start_rd same clock → write burst only, no rd_valid. start_rd while busy → ignored.
- Selector changes mux_data mid-D_STRB → RTC bus still shows the byte latched at D_SETUP entry.
- With RTC_BURST_ABORT_EN, abort during channel 5 A_SETUP → channel 5 completes, done+aborted after its GAP, no channel 6 cycle.
